baud_cfg_ctrl: RTL and testbench
================================

// Module: baud_cfg_ctrl
// PURPOSE
//  Sequences run-time baud-rate changes for the shared 16x baud tick generator.
//  NREQ requesters (UART channels, CSR port) issue change requests; round-robin arbitration picks one.
//  Each request is validated against the supported-rate table and applied only once the line has drained.
//  The block then waits for the new tick to settle before acknowledging.
//  Sits between the requesters and the generator's divisor/load/hold inputs.
// PARAMETERS
//  NREQ          2            number of requesters (1..8)
//  SYS_CLK_FREQ  100_000_000  system clock, Hz
//  DIV_W         16           divisor width
//  SETTLE_TICKS  2            tick_in pulses to wait after load before ack
//  DRAIN_MAX     65535        clk cycles allowed for line_busy to clear before nack
// PORTS
//  clk        in   1          system clock
//  rst        in   1          synchronous, active-high reset
//  req        in   NREQ       per-requester request level
//  req_baud   in   NREQ*17    requested baud; requester i uses bits [17*i +: 17]
//  ack        out  NREQ       one-cycle pulse: change applied (or already current)
//  nack       out  NREQ       one-cycle pulse: unsupported rate or drain timeout; nothing changed
//  line_busy  in   1          tx/rx frame in flight on the line using the generator
//  tick_in    in   1          16x tick pulse from the generator
//  gen_div    out  DIV_W      divisor to generator = SYS_CLK_FREQ/(16*baud)
//  gen_load   out  1          one-cycle pulse; generator reloads divisor and clears its counter
//  gen_hold   out  1          high from grant to load: line users must not start a new frame
//  cur_baud   out  17         currently applied baud
//  cfg_busy   out  1          high whenever FSM != IDLE
// BEHAVIOUR
//  Reset: FSM=IDLE, cur_baud=9600, gen_div=651, ack/nack/gen_load/gen_hold=0, rr pointer=0.
//  Supported rates at 100 MHz (truncating divide):
//   4800->1302, 9600->651, 14400->434, 19200->325, 38400->162, 57600->108.
//  Any other value is unsupported and is nacked; there is no default rate.
//  Handshake:
//   - Requester holds req and req_baud stable until it sees ack or nack.
//   - Requester drops req in the cycle after the response.
//   - A req that falls before its response is a protocol error; behaviour is don't-care, no hang required.
//  FSM states:
//   IDLE:   if any req, go to GRANT. Round-robin starts at rr pointer, lowest index wins ties.
//   GRANT:  latch grant index, baud, and LUT result.
//           invalid -> RESP(nack); baud==cur_baud -> RESP(ack), no reload; else -> DRAIN with gen_hold=1.
//   DRAIN:  count cycles. When line_busy==0 -> LOAD.
//           If count reaches DRAIN_MAX -> RESP(nack) with gen_hold=0 and no change.
//   LOAD:   one cycle. gen_load=1; gen_div and cur_baud update this cycle; gen_hold drops. -> SETTLE.
//   SETTLE: count tick_in pulses; a tick in the LOAD cycle is ignored. On the SETTLE_TICKS-th pulse -> RESP(ack).
//   RESP:   one cycle; ack or nack[grant]=1. rr pointer = grant+1 mod NREQ. -> IDLE.
//  Latency, line idle, valid new rate: req seen at cycle 0.
//   GRANT c1, DRAIN c2, LOAD c3, then SETTLE; ack appears the cycle after the last settle tick.
//  Same-rate request: ack at c2. Invalid request: nack at c2.
//  Requests arriving while cfg_busy are held pending. At most one grant is in flight.
//  A requester is never granted twice in a row while another requester is waiting.
//  rst mid-operation: immediate return to reset values. The pending change is lost and no ack is issued.
//  gen_div is only ever written in LOAD.
// STRUCTURE
//  baud_pkg:
//   - supported-rate list and the SYS_CLK_FREQ-based divisor function
//   - state enum {IDLE,GRANT,DRAIN,LOAD,SETTLE,RESP}
//   - BAUD_W=17 and RESET_BAUD=9600
//  Sub-module baud_div_lut: combinational baud -> {valid, div}.
//  It is shared with any CSR readback logic.
//  Arbiter, FSM and counters stay in baud_cfg_ctrl.
// TESTING
//  1. Reset, hold line_busy=0, req[0] for 19200
//     -> gen_load pulses at c3 with gen_div=325; ack[0] on cycle after 2nd tick_in; cur_baud=19200.
//  2. req[1] for 12345 -> nack[1] at c2; gen_load never pulses; gen_div stays 651.
//  3. req[0] for 9600 straight after reset -> ack[0] at c2; no gen_load.
//  4. line_busy=1 for 40 cycles, req[0] for 57600
//     -> gen_hold high throughout; load occurs the cycle after line_busy falls; div=108.
//     With DRAIN_MAX=16 instead -> nack[0], gen_hold drops, no load.
//  5. req[0] and req[1] asserted together, each re-requesting after its response
//     -> grants alternate 0,1,0,1; no back-to-back grant to the same requester.
//  6. rst asserted during SETTLE -> next cycle cur_baud=9600, gen_div=651, cfg_busy=0, no ack/nack pulse.

Source files
------------

// File: rtl/baud_pkg.sv
// Shared definitions for the baud-rate change sequencer: supported-rate table,
// divisor arithmetic and the controller state encoding.
package baud_pkg;

    localparam int BAUD_W    = 17;
    localparam int NUM_RATES = 6;

    localparam logic [BAUD_W-1:0] RESET_BAUD = 17'd9600;

    localparam logic [BAUD_W-1:0] RATE_LIST [NUM_RATES] = '{
        17'd4800, 17'd9600, 17'd14400, 17'd19200, 17'd38400, 17'd57600
    };

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        DRAIN,
        LOAD,
        SETTLE,
        RESP
    } cfg_state_t;

    // Generator runs at 16x the line rate; the divide truncates.
    function automatic int unsigned baud_div(input int unsigned sys_clk_freq,
                                             input int unsigned baud);
        return sys_clk_freq / (16 * baud);
    endfunction

endpackage

// File: rtl/baud_div_lut.sv
// Combinational baud -> {valid, divisor} lookup over the supported-rate table.
// Divisors are elaborated from the system clock, so no arithmetic is built in logic.
module baud_div_lut
    import baud_pkg::*;
#(
    parameter int unsigned SYS_CLK_FREQ = 100_000_000,
    parameter int          DIV_W        = 16
) (
    input  logic [BAUD_W-1:0] baud,
    output logic              valid,
    output logic [DIV_W-1:0]  div
);

    logic [NUM_RATES-1:0] hit;
    logic [DIV_W-1:0]     div_tab [NUM_RATES];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RATES; gi++) begin : g_rate
            localparam int unsigned DIV_I = baud_div(SYS_CLK_FREQ, 32'(RATE_LIST[gi]));
            assign hit[gi]     = (baud == RATE_LIST[gi]);
            assign div_tab[gi] = DIV_W'(DIV_I);
        end
    endgenerate

    // Rates are distinct, so at most one entry hits.
    always_comb begin
        valid = |hit;
        div   = '0;
        for (int i = 0; i < NUM_RATES; i++) begin
            if (hit[i]) begin
                div = div_tab[i];
            end
        end
    end

endmodule

// File: rtl/baud_cfg_ctrl.sv
// Round-robin sequencer for run-time baud changes: validates a request, waits for
// the line to drain, reloads the tick generator and waits for the tick to settle.
module baud_cfg_ctrl
    import baud_pkg::*;
#(
    parameter int          NREQ         = 2,
    parameter int unsigned SYS_CLK_FREQ = 100_000_000,
    parameter int          DIV_W        = 16,
    parameter int unsigned SETTLE_TICKS = 2,
    parameter int unsigned DRAIN_MAX    = 65535
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*BAUD_W-1:0] req_baud,
    output logic [NREQ-1:0]        ack,
    output logic [NREQ-1:0]        nack,
    input  logic                   line_busy,
    input  logic                   tick_in,
    output logic [DIV_W-1:0]       gen_div,
    output logic                   gen_load,
    output logic                   gen_hold,
    output logic [BAUD_W-1:0]      cur_baud,
    output logic                   cfg_busy
);

    localparam int IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DRAIN_W = $clog2(DRAIN_MAX + 1);
    localparam int TICK_W  = $clog2(SETTLE_TICKS + 1);

    localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(baud_div(SYS_CLK_FREQ, 32'(RESET_BAUD)));

    cfg_state_t         state_reg;
    logic [IDX_W-1:0]   grant_reg;
    logic [IDX_W-1:0]   rr_reg;
    logic [BAUD_W-1:0]  baud_reg;
    logic [DIV_W-1:0]   div_reg;
    logic [DRAIN_W-1:0] drain_cnt_reg;
    logic [TICK_W-1:0]  tick_cnt_reg;
    logic [BAUD_W-1:0]  cur_baud_reg;
    logic [DIV_W-1:0]   gen_div_reg;
    logic               gen_load_reg;
    logic               gen_hold_reg;
    logic [NREQ-1:0]    ack_reg;
    logic [NREQ-1:0]    nack_reg;

    logic [BAUD_W-1:0]  req_baud_arr [NREQ];
    logic [IDX_W-1:0]   arb_idx;
    logic               lut_valid;
    logic [DIV_W-1:0]   lut_div;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign req_baud_arr[gi] = req_baud[gi*BAUD_W +: BAUD_W];
        end
    endgenerate

    // Scan upward from the round-robin pointer, wrapping; first requester found wins.
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        found   = 1'b0;
        cand    = '0;
        arb_idx = rr_reg;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDX_W'((32'(rr_reg) + 32'(k)) % NREQ);
            if (!found && req[cand]) begin
                arb_idx = cand;
                found   = 1'b1;
            end
        end
    end

    baud_div_lut #(
        .SYS_CLK_FREQ (SYS_CLK_FREQ),
        .DIV_W        (DIV_W)
    ) u_lut (
        .baud  (baud_reg),
        .valid (lut_valid),
        .div   (lut_div)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            rr_reg        <= '0;
            baud_reg      <= '0;
            div_reg       <= '0;
            drain_cnt_reg <= '0;
            tick_cnt_reg  <= '0;
            cur_baud_reg  <= RESET_BAUD;
            gen_div_reg   <= RESET_DIV;
            gen_load_reg  <= 1'b0;
            gen_hold_reg  <= 1'b0;
            ack_reg       <= '0;
            nack_reg      <= '0;
        end else begin
            gen_load_reg <= 1'b0;
            ack_reg      <= '0;
            nack_reg     <= '0;
            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        grant_reg <= arb_idx;
                        baud_reg  <= req_baud_arr[arb_idx];
                        state_reg <= GRANT;
                    end
                end
                GRANT: begin
                    div_reg       <= lut_div;
                    drain_cnt_reg <= '0;
                    if (!lut_valid) begin
                        nack_reg[grant_reg] <= 1'b1;
                        state_reg           <= RESP;
                    end else if (baud_reg == cur_baud_reg) begin
                        ack_reg[grant_reg] <= 1'b1;
                        state_reg          <= RESP;
                    end else begin
                        gen_hold_reg <= 1'b1;
                        state_reg    <= DRAIN;
                    end
                end
                DRAIN: begin
                    // An idle line wins over a timeout landing in the same cycle.
                    if (!line_busy) begin
                        gen_load_reg <= 1'b1;
                        gen_div_reg  <= div_reg;
                        cur_baud_reg <= baud_reg;
                        gen_hold_reg <= 1'b0;
                        state_reg    <= LOAD;
                    end else if (drain_cnt_reg == DRAIN_W'(DRAIN_MAX - 1)) begin
                        nack_reg[grant_reg] <= 1'b1;
                        gen_hold_reg        <= 1'b0;
                        state_reg           <= RESP;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg + 1'b1;
                    end
                end
                LOAD: begin
                    // A tick coincident with the reload belongs to the old divisor.
                    tick_cnt_reg <= '0;
                    state_reg    <= SETTLE;
                end
                SETTLE: begin
                    if (tick_in) begin
                        if (tick_cnt_reg == TICK_W'(SETTLE_TICKS - 1)) begin
                            ack_reg[grant_reg] <= 1'b1;
                            state_reg          <= RESP;
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end
                end
                RESP: begin
                    rr_reg    <= (grant_reg == IDX_W'(NREQ - 1)) ? '0 : grant_reg + 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ack      = ack_reg;
    assign nack     = nack_reg;
    assign gen_div  = gen_div_reg;
    assign gen_load = gen_load_reg;
    assign gen_hold = gen_hold_reg;
    assign cur_baud = cur_baud_reg;
    assign cfg_busy = (state_reg != IDLE);

endmodule

// File: tb/tb_baud_cfg_ctrl.sv
// Randomized self-checking bench for baud_cfg_ctrl against a transaction-level
// model of the rate table, drain timeout and settle-tick rules.
module tb_baud_cfg_ctrl;

    localparam int DRAIN_MAX_TB    = 48;
    localparam int SETTLE_TICKS_TB = 2;
    localparam int BUDGET          = 300;

    typedef struct packed {
        int          resp_cycle;
        logic        is_ack;
        int          load_count;
        int          load_cycle;
        logic [15:0] load_div;
        int          hold_count;
        logic        stray;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [33:0] req_baud;
    logic [1:0]  ack;
    logic [1:0]  nack;
    logic        line_busy;
    logic        tick_in;
    logic [15:0] gen_div;
    logic        gen_load;
    logic        gen_hold;
    logic [16:0] cur_baud;
    logic        cfg_busy;

    int n_checks = 0;
    int n_fail   = 0;

    int          rates [6] = '{4800, 9600, 14400, 19200, 38400, 57600};
    int          divs  [6] = '{1302, 651, 434, 325, 162, 108};
    logic [16:0] model_cur;
    logic [15:0] model_div;
    int          tick_q [$];
    int          grant_q [$];
    int          rr_timeouts;

    always #5 clk = ~clk;

    baud_cfg_ctrl #(
        .NREQ         (2),
        .SYS_CLK_FREQ (100_000_000),
        .DIV_W        (16),
        .SETTLE_TICKS (SETTLE_TICKS_TB),
        .DRAIN_MAX    (DRAIN_MAX_TB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_baud  (req_baud),
        .ack       (ack),
        .nack      (nack),
        .line_busy (line_busy),
        .tick_in   (tick_in),
        .gen_div   (gen_div),
        .gen_load  (gen_load),
        .gen_hold  (gen_hold),
        .cur_baud  (cur_baud),
        .cfg_busy  (cfg_busy)
    );

    task automatic do_reset();
        rst       = 1'b1;
        req       = '0;
        req_baud  = '0;
        line_busy = 1'b0;
        tick_in   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst       = 1'b0;
        model_cur = 17'd9600;
        model_div = 16'd651;
    endtask

    // Expected outcome from the rules; a settle ack time is filled in from the ticks driven.
    function automatic txn_t model_txn(input logic [16:0] b, input int busy);
        txn_t e;
        int   idx = -1;
        e = '{resp_cycle: 2, is_ack: 1'b0, load_count: 0, load_cycle: -1,
              load_div: 16'd0, hold_count: 0, stray: 1'b0};
        for (int i = 0; i < 6; i++) if (rates[i] == int'(b)) idx = i;
        if (idx < 0) begin
            e.is_ack = 1'b0;
        end else if (b == model_cur) begin
            e.is_ack = 1'b1;
        end else if (busy >= DRAIN_MAX_TB) begin
            e.resp_cycle = 2 + DRAIN_MAX_TB;
            e.hold_count = DRAIN_MAX_TB;
        end else begin
            e.is_ack     = 1'b1;
            e.load_count = 1;
            e.load_cycle = 3 + busy;
            e.load_div   = 16'(divs[idx]);
            e.hold_count = busy + 1;
        end
        return e;
    endfunction

    function automatic int settle_ack(input int load_c);
        int seen = 0;
        foreach (tick_q[i]) begin
            if (tick_q[i] > load_c) begin
                seen++;
                if (seen == SETTLE_TICKS_TB) return tick_q[i] + 1;
            end
        end
        return -3;
    endfunction

    // One requester transaction; line_busy stays high for `busy` cycles of drain.
    task automatic drive_txn(input int r, input logic [16:0] b, input int busy,
                             output txn_t o);
        int         n = 0;
        logic [1:0] mask;
        mask = 2'b01 << r;
        o = '{resp_cycle: -1, is_ack: 1'b0, load_count: 0, load_cycle: -1,
              load_div: 16'd0, hold_count: 0, stray: 1'b0};
        tick_q.delete();
        req_baud[r*17 +: 17] = b;
        req[r]    = 1'b1;
        line_busy = (busy > 0);
        tick_in   = 1'b0;
        while (n < BUDGET) begin
            @(posedge clk);
            #1;
            n++;
            if (gen_load) begin
                o.load_count++;
                o.load_cycle = n;
                o.load_div   = gen_div;
            end
            if (gen_hold) o.hold_count++;
            if (((ack | nack) & ~mask) != 2'b00) o.stray = 1'b1;
            if (ack[r] || nack[r]) begin
                if (ack[r] && nack[r]) o.stray = 1'b1;
                o.resp_cycle = n;
                o.is_ack     = ack[r];
                req[r]       = 1'b0;
                break;
            end
            line_busy = (busy > 0) && (n < 2 + busy);
            tick_in   = gen_load ? 1'b1 : ($urandom_range(99) < 30);
            if (tick_in) tick_q.push_back(n);
        end
        req[r]    = 1'b0;
        line_busy = 1'b0;
        tick_in   = 1'b0;
        @(posedge clk);
        #1;
        if (ack != 2'b00 || nack != 2'b00 || gen_load) o.stray = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (cur_baud !== 17'd9600) begin n_fail++; $display("FAIL reset_cur_baud: got %0d expected 9600", cur_baud); end
        n_checks++; if (gen_div !== 16'd651) begin n_fail++; $display("FAIL reset_gen_div: got %0d expected 651", gen_div); end
        n_checks++; if ({ack, nack, gen_load, gen_hold, cfg_busy} !== 7'b0) begin
            n_fail++; $display("FAIL reset_outputs: got ack=%b nack=%b load=%b hold=%b busy=%b expected all 0",
                               ack, nack, gen_load, gen_hold, cfg_busy);
        end
    endtask

    task automatic test_valid_change();
        txn_t o;
        int   exp_ack;
        do_reset();
        drive_txn(0, 17'd19200, 0, o);
        exp_ack = settle_ack(3);
        n_checks++; if (o.load_cycle !== 3 || o.load_count !== 1) begin n_fail++; $display("FAIL change_load: got cycle %0d count %0d expected cycle 3 count 1", o.load_cycle, o.load_count); end
        n_checks++; if (o.load_div !== 16'd325) begin n_fail++; $display("FAIL change_div: got %0d expected 325", o.load_div); end
        n_checks++; if (o.resp_cycle !== exp_ack || o.is_ack !== 1'b1) begin n_fail++; $display("FAIL change_ack: got cycle %0d ack %0b expected cycle %0d ack 1", o.resp_cycle, o.is_ack, exp_ack); end
        n_checks++; if (cur_baud !== 17'd19200 || o.stray !== 1'b0) begin n_fail++; $display("FAIL change_cur_baud: got %0d stray %0b expected 19200 stray 0", cur_baud, o.stray); end
    endtask

    task automatic test_invalid();
        txn_t        o;
        logic [16:0] bad [3] = '{17'd12345, 17'd9601, 17'd0};
        do_reset();
        foreach (bad[i]) begin
            drive_txn(1, bad[i], 0, o);
            n_checks++; if (o.resp_cycle !== 2 || o.is_ack !== 1'b0) begin n_fail++; $display("FAIL invalid_nack(%0d): got cycle %0d ack %0b expected nack at 2", bad[i], o.resp_cycle, o.is_ack); end
            n_checks++; if (o.load_count !== 0 || o.hold_count !== 0 || gen_div !== 16'd651) begin n_fail++; $display("FAIL invalid_no_change(%0d): got loads %0d holds %0d div %0d expected 0 0 651", bad[i], o.load_count, o.hold_count, gen_div); end
        end
    endtask

    task automatic test_same_rate();
        txn_t o;
        do_reset();
        drive_txn(0, 17'd9600, 0, o);
        n_checks++; if (o.resp_cycle !== 2 || o.is_ack !== 1'b1) begin n_fail++; $display("FAIL same_ack: got cycle %0d ack %0b expected ack at 2", o.resp_cycle, o.is_ack); end
        n_checks++; if (o.load_count !== 0 || o.stray !== 1'b0) begin n_fail++; $display("FAIL same_no_load: got loads %0d stray %0b expected 0 0", o.load_count, o.stray); end
    endtask

    task automatic test_drain();
        txn_t o;
        int   exp_ack;
        do_reset();
        drive_txn(0, 17'd57600, 40, o);
        exp_ack = settle_ack(43);
        n_checks++; if (o.load_cycle !== 43 || o.load_div !== 16'd108) begin n_fail++; $display("FAIL drain40_load: got cycle %0d div %0d expected 43 108", o.load_cycle, o.load_div); end
        n_checks++; if (o.hold_count !== 41 || o.resp_cycle !== exp_ack) begin n_fail++; $display("FAIL drain40_hold_ack: got hold %0d ack %0d expected 41 %0d", o.hold_count, o.resp_cycle, exp_ack); end
        drive_txn(1, 17'd38400, DRAIN_MAX_TB - 1, o);
        n_checks++; if (o.load_cycle !== DRAIN_MAX_TB + 2 || o.load_div !== 16'd162 || o.is_ack !== 1'b1) begin n_fail++; $display("FAIL drain_edge_load: got cycle %0d div %0d ack %0b expected %0d 162 1", o.load_cycle, o.load_div, o.is_ack, DRAIN_MAX_TB + 2); end
        drive_txn(0, 17'd4800, DRAIN_MAX_TB, o);
        n_checks++; if (o.resp_cycle !== DRAIN_MAX_TB + 2 || o.is_ack !== 1'b0) begin n_fail++; $display("FAIL drain_timeout_nack: got cycle %0d ack %0b expected nack at %0d", o.resp_cycle, o.is_ack, DRAIN_MAX_TB + 2); end
        n_checks++; if (o.load_count !== 0 || o.hold_count !== DRAIN_MAX_TB || gen_hold !== 1'b0) begin n_fail++; $display("FAIL drain_timeout_hold: got loads %0d hold %0d hold_now %0b expected 0 %0d 0", o.load_count, o.hold_count, gen_hold, DRAIN_MAX_TB); end
        n_checks++; if (cur_baud !== 17'd38400 || gen_div !== 16'd162) begin n_fail++; $display("FAIL drain_timeout_keep: got %0d/%0d expected 38400/162", cur_baud, gen_div); end
    endtask

    task automatic requester(input int r, input logic [16:0] b, input int count);
        for (int k = 0; k < count; k++) begin
            int   waited = 0;
            logic got    = 1'b0;
            req_baud[r*17 +: 17] = b;
            req[r] = 1'b1;
            while (!got && waited < 200) begin
                @(posedge clk);
                #1;
                waited++;
                if (ack[r] || nack[r]) begin
                    got = 1'b1;
                    grant_q.push_back(r);
                end
            end
            req[r] = 1'b0;
            if (!got) rr_timeouts++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        grant_q.delete();
        rr_timeouts = 0;
        fork
            requester(0, 17'd9600, 4);
            requester(1, 17'd1000, 4);
        join
        req = '0;
        n_checks++; if (grant_q.size() !== 8 || rr_timeouts !== 0) begin n_fail++; $display("FAIL rr_count: got %0d grants %0d timeouts expected 8 0", grant_q.size(), rr_timeouts); end
        foreach (grant_q[i]) begin
            n_checks++; if (grant_q[i] !== i % 2) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, grant_q[i], i % 2); end
        end
    endtask

    task automatic test_reset_mid();
        logic noisy = 1'b0;
        do_reset();
        req_baud[16:0] = 17'd14400;
        req[0] = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        n_checks++; if (cur_baud !== 17'd14400 || gen_div !== 16'd434 || cfg_busy !== 1'b1) begin n_fail++; $display("FAIL settle_state: got %0d/%0d busy %0b expected 14400/434 busy 1", cur_baud, gen_div, cfg_busy); end
        rst    = 1'b1;
        req[0] = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (cur_baud !== 17'd9600 || gen_div !== 16'd651 || cfg_busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_values: got %0d/%0d busy %0b expected 9600/651 busy 0", cur_baud, gen_div, cfg_busy); end
        rst     = 1'b0;
        tick_in = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (ack != 2'b00 || nack != 2'b00 || gen_load) noisy = 1'b1;
        end
        tick_in = 1'b0;
        n_checks++; if (noisy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_quiet: got response or load %0b expected 0", noisy); end
        model_cur = 17'd9600;
        model_div = 16'd651;
    endtask

    task automatic test_random();
        txn_t        o, e;
        logic [16:0] b;
        int          r, busy, sel;
        do_reset();
        for (int t = 0; t < 25; t++) begin
            r   = $urandom_range(1);
            sel = $urandom_range(9);
            if (sel < 6)      b = 17'(rates[$urandom_range(5)]);
            else if (sel < 8) b = model_cur;
            else              b = 17'($urandom_range(131071));
            sel = $urandom_range(9);
            if (sel < 6)       busy = 0;
            else if (sel < 8)  busy = $urandom_range(12, 1);
            else if (sel == 8) busy = DRAIN_MAX_TB - 1;
            else               busy = DRAIN_MAX_TB;
            e = model_txn(b, busy);
            drive_txn(r, b, busy, o);
            if (e.load_count == 1) begin
                e.resp_cycle = settle_ack(e.load_cycle);
                model_cur    = b;
                model_div    = e.load_div;
            end
            n_checks++; if (o.resp_cycle !== e.resp_cycle || o.is_ack !== e.is_ack) begin n_fail++; $display("FAIL rand%0d_resp(r=%0d b=%0d busy=%0d): got cycle %0d ack %0b expected cycle %0d ack %0b", t, r, b, busy, o.resp_cycle, o.is_ack, e.resp_cycle, e.is_ack); end
            n_checks++; if (o.load_count !== e.load_count || o.load_cycle !== e.load_cycle || o.load_div !== e.load_div) begin n_fail++; $display("FAIL rand%0d_load: got n=%0d cycle %0d div %0d expected n=%0d cycle %0d div %0d", t, o.load_count, o.load_cycle, o.load_div, e.load_count, e.load_cycle, e.load_div); end
            n_checks++; if (o.hold_count !== e.hold_count || o.stray !== 1'b0) begin n_fail++; $display("FAIL rand%0d_hold: got hold %0d stray %0b expected hold %0d stray 0", t, o.hold_count, o.stray, e.hold_count); end
            n_checks++; if (cur_baud !== model_cur || gen_div !== model_div) begin n_fail++; $display("FAIL rand%0d_state: got %0d/%0d expected %0d/%0d", t, cur_baud, gen_div, model_cur, model_div); end
        end
    endtask

    initial begin
        test_reset();
        test_valid_change();
        test_invalid();
        test_same_rate();
        test_drain();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
